// File: rtl/wb_sb_pkg.sv
// wb_sb_pkg: shared definitions for the writeback scoreboard.
//   - sb_state_e : scoreboard FSM states
//   - DEF_*      : default parameter values used by the interface and top
package wb_sb_pkg;

   localparam int unsigned DEF_XLEN      = 32;
   localparam int unsigned DEF_NREG      = 32;
   localparam int unsigned DEF_NCHK      = 10;
   localparam int unsigned DEF_QUIET_CYC = 20;
   localparam int unsigned DEF_MAX_CYC   = 1000;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CHECK,
      DONE
   } sb_state_e;

endpackage

// File: rtl/wb_scoreboard_if.sv
// wb_scoreboard_if: control, configuration, writeback snoop and verdict
// signals of the scoreboard.
//   master : drives start, cfg_*, wb_*; observes the verdict
//   slave  : the scoreboard side
interface wb_scoreboard_if
   import wb_sb_pkg::*;
#(
   parameter int unsigned XLEN    = DEF_XLEN,
   parameter int unsigned NREG    = DEF_NREG,
   parameter int unsigned NCHK    = DEF_NCHK,
   parameter int unsigned MAX_CYC = DEF_MAX_CYC
);
   localparam int unsigned RW  = $clog2(NREG);
   localparam int unsigned CW  = $clog2(NCHK);
   localparam int unsigned CCW = $clog2(MAX_CYC + 1);

   logic            start;
   logic            cfg_we;
   logic [CW-1:0]   cfg_idx;
   logic [RW-1:0]   cfg_rd;
   logic [XLEN-1:0] cfg_data;
   logic            cfg_en;
   logic            wb_en;
   logic [RW-1:0]   wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            busy;
   logic            done;
   logic            pass;
   logic            timeout;
   logic [CW-1:0]   fail_idx;
   logic [XLEN-1:0] fail_got;
   logic [CCW-1:0]  cycle_cnt;
   logic [31:0]     retire_cnt;

   modport master (
      output start, cfg_we, cfg_idx, cfg_rd, cfg_data, cfg_en, wb_en, wb_rd, wb_data,
      input  busy, done, pass, timeout, fail_idx, fail_got, cycle_cnt, retire_cnt
   );

   modport slave (
      input  start, cfg_we, cfg_idx, cfg_rd, cfg_data, cfg_en, wb_en, wb_rd, wb_data,
      output busy, done, pass, timeout, fail_idx, fail_got, cycle_cnt, retire_cnt
   );

endinterface

// File: rtl/sb_shadow_rf.sv
// sb_shadow_rf: shadow register file with per-register written bitmap.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clr_i         : synchronous clear of values and bitmap
//   we_i/waddr_i/wdata_i : write port (writes to x0 are dropped)
//   raddr_i       : combinational read address
//   rdata_o/rwritten_o   : value and written flag (x0 reads as written, 0)
module sb_shadow_rf #(
   parameter  int unsigned XLEN = 32,
   parameter  int unsigned NREG = 32,
   localparam int unsigned RW   = $clog2(NREG)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            we_i,
   input  logic [RW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [RW-1:0]   raddr_i,
   output logic [XLEN-1:0] rdata_o,
   output logic            rwritten_o
);

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] wr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
         wr_q <= '0;
      end else if (clr_i) begin
         for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
         wr_q <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
         wr_q[waddr_i]  <= 1'b1;
      end
   end

   always_comb begin
      rdata_o    = '0;
      rwritten_o = 1'b1;
      if (raddr_i != '0) begin
         rdata_o    = mem_q[raddr_i];
         rwritten_o = wr_q[raddr_i];
      end
   end

endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: snoops the core's writeback port into a shadow register
// file and, once the core goes quiet or the cycle budget runs out, checks
// the programmed expectation slots and reports a pass/fail verdict.
//   clk, rst : clock, asynchronous active-high reset
//   sb       : slave side of wb_scoreboard_if (start, cfg_*, wb_*, verdict)
module wb_scoreboard
   import wb_sb_pkg::*;
#(
   parameter int unsigned XLEN      = DEF_XLEN,
   parameter int unsigned NREG      = DEF_NREG,
   parameter int unsigned NCHK      = DEF_NCHK,
   parameter int unsigned QUIET_CYC = DEF_QUIET_CYC,
   parameter int unsigned MAX_CYC   = DEF_MAX_CYC
) (
   input logic            clk,
   input logic            rst,
   wb_scoreboard_if.slave sb
);

   localparam int unsigned RW  = $clog2(NREG);
   localparam int unsigned CW  = $clog2(NCHK);
   localparam int unsigned CCW = $clog2(MAX_CYC + 1);
   localparam int unsigned QW  = $clog2(QUIET_CYC + 1);

   sb_state_e       state_q, state_d;
   logic [QW-1:0]   quiet_q, quiet_d;
   logic [CCW-1:0]  cycle_q, cycle_d;
   logic [31:0]     retire_q, retire_d;
   logic [CW-1:0]   scan_q, scan_d;
   logic            timeout_q, timeout_d;
   logic            fail_q, fail_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [CW-1:0]   fail_idx_q, fail_idx_d;
   logic [XLEN-1:0] fail_got_q, fail_got_d;

   logic [NCHK-1:0] slot_en_q;
   logic [RW-1:0]   slot_rd_q   [NCHK];
   logic [XLEN-1:0] slot_data_q [NCHK];

   logic            rf_clr, rf_we, rf_written, slot_fail, cfg_ok;
   logic [XLEN-1:0] rf_rdata;
   logic            quiet_hit, cyc_hit;

   sb_shadow_rf #(.XLEN(XLEN), .NREG(NREG)) u_rf (
      .clk_i     (clk),
      .rst_i     (rst),
      .clr_i     (rf_clr),
      .we_i      (rf_we),
      .waddr_i   (sb.wb_rd),
      .wdata_i   (sb.wb_data),
      .raddr_i   (slot_rd_q[scan_q]),
      .rdata_o   (rf_rdata),
      .rwritten_o(rf_written)
   );

   assign cfg_ok = sb.cfg_we && ((state_q == IDLE) || (state_q == DONE))
                   && (32'(sb.cfg_idx) < NCHK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_en_q <= '0;
         for (int unsigned i = 0; i < NCHK; i++) begin
            slot_rd_q[i]   <= '0;
            slot_data_q[i] <= '0;
         end
      end else if (cfg_ok) begin
         slot_en_q[sb.cfg_idx]   <= sb.cfg_en;
         slot_rd_q[sb.cfg_idx]   <= sb.cfg_rd;
         slot_data_q[sb.cfg_idx] <= sb.cfg_data;
      end
   end

   // Unwritten registers fail regardless of value; x0 reads as written zero.
   assign slot_fail = slot_en_q[scan_q] &&
                      (!rf_written || (rf_rdata != slot_data_q[scan_q]));

   // Quiet exit fires on the QUIET_CYC-th consecutive idle edge.
   assign quiet_hit = !sb.wb_en && (quiet_q == QW'(QUIET_CYC - 1));
   assign cyc_hit   = (cycle_q == CCW'(MAX_CYC - 1));

   always_comb begin
      state_d    = state_q;
      quiet_d    = quiet_q;
      cycle_d    = cycle_q;
      retire_d   = retire_q;
      scan_d     = scan_q;
      timeout_d  = timeout_q;
      fail_d     = fail_q;
      done_d     = done_q;
      pass_d     = pass_q;
      fail_idx_d = fail_idx_q;
      fail_got_d = fail_got_q;
      rf_clr     = 1'b0;
      rf_we      = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (sb.start) begin
               state_d    = RUN;
               rf_clr     = 1'b1;
               quiet_d    = '0;
               cycle_d    = '0;
               retire_d   = '0;
               scan_d     = '0;
               timeout_d  = 1'b0;
               fail_d     = 1'b0;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               fail_idx_d = '0;
               fail_got_d = '0;
            end
         end
         RUN: begin
            if (cycle_q != CCW'(MAX_CYC)) cycle_d = cycle_q + 1'b1;
            if (sb.wb_en) begin
               quiet_d = '0;
               if (sb.wb_rd != '0) begin
                  rf_we    = 1'b1;
                  retire_d = retire_q + 32'd1;
               end
            end else begin
               quiet_d = quiet_q + 1'b1;
            end
            if (quiet_hit || cyc_hit) begin
               state_d   = CHECK;
               timeout_d = cyc_hit;
               scan_d    = '0;
            end
         end
         CHECK: begin
            if (slot_fail && !fail_q) begin
               fail_d     = 1'b1;
               fail_idx_d = scan_q;
               fail_got_d = rf_written ? rf_rdata : '0;
            end
            if (scan_q == CW'(NCHK - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = !(fail_q || slot_fail) && !timeout_q;
            end else begin
               scan_d = scan_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         quiet_q    <= '0;
         cycle_q    <= '0;
         retire_q   <= '0;
         scan_q     <= '0;
         timeout_q  <= 1'b0;
         fail_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_idx_q <= '0;
         fail_got_q <= '0;
      end else begin
         state_q    <= state_d;
         quiet_q    <= quiet_d;
         cycle_q    <= cycle_d;
         retire_q   <= retire_d;
         scan_q     <= scan_d;
         timeout_q  <= timeout_d;
         fail_q     <= fail_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         fail_idx_q <= fail_idx_d;
         fail_got_q <= fail_got_d;
      end
   end

   assign sb.busy       = (state_q == RUN) || (state_q == CHECK);
   assign sb.done       = done_q;
   assign sb.pass       = pass_q;
   assign sb.timeout    = timeout_q;
   assign sb.fail_idx   = fail_idx_q;
   assign sb.fail_got   = fail_got_q;
   assign sb.cycle_cnt  = cycle_q;
   assign sb.retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: table-driven and randomized bench for wb_scoreboard
// (MAX_CYC reduced to 50 so the budget corner is reachable quickly).
module tb_wb_scoreboard;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned NCHK  = 10;
   localparam int unsigned QUIET = 20;
   localparam int unsigned MAXC  = 50;

   typedef struct {
      logic        en;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   typedef struct {
      int          slot;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        en;
      bit          inject;
      bit          e_pass;
      int          e_fidx;
      logic [31:0] e_fgot;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NCHK(NCHK), .MAX_CYC(MAXC)) sb ();

   wb_scoreboard #(
      .XLEN(XLEN), .NREG(NREG), .NCHK(NCHK), .QUIET_CYC(QUIET), .MAX_CYC(MAXC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sb (sb)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   wb_t         prog[$];
   wb_t         prog_ref[$];
   logic        s_en   [NCHK];
   logic [4:0]  s_rd   [NCHK];
   logic [31:0] s_data [NCHK];
   int          m_exit, m_retire, m_fidx;
   bit          m_timeout, m_pass;
   logic [31:0] m_fgot;
   int          done_edge;
   vec_t        vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".busy"},       sb.busy,       0);
      chk({tag, ".done"},       sb.done,       0);
      chk({tag, ".pass"},       sb.pass,       0);
      chk({tag, ".timeout"},    sb.timeout,    0);
      chk({tag, ".fail_idx"},   sb.fail_idx,   0);
      chk({tag, ".fail_got"},   sb.fail_got,   0);
      chk({tag, ".cycle_cnt"},  sb.cycle_cnt,  0);
      chk({tag, ".retire_cnt"}, sb.retire_cnt, 0);
   endtask

   task automatic base_slots();
      logic [4:0]  rds [9] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10};
      logic [31:0] dts [9] = '{32'd7, 32'd8, 32'd15, 32'd15, 32'd22, 32'd23, 32'd100, 32'd200, 32'd77};
      for (int i = 0; i < 9; i++) begin
         s_en[i] = 1'b1; s_rd[i] = rds[i]; s_data[i] = dts[i];
      end
      s_en[9] = 1'b0; s_rd[9] = '0; s_data[9] = '0;
   endtask

   task automatic program_slots();
      for (int i = 0; i < NCHK; i++) begin
         sb.cfg_we = 1'b1; sb.cfg_idx = 4'(i);
         sb.cfg_rd = s_rd[i]; sb.cfg_data = s_data[i]; sb.cfg_en = s_en[i];
         tick();
      end
      sb.cfg_we = 1'b0;
   endtask

   // Reference: walk RUN cycles 1..MAXC, apply writebacks, find the exit
   // cycle, then evaluate every slot against the final register image.
   task automatic model();
      logic [31:0] shadow [NREG];
      bit          wr [NREG];
      int          last = 0;
      bit          failed = 0;
      for (int r = 0; r < NREG; r++) begin shadow[r] = '0; wr[r] = (r == 0); end
      m_retire = 0; m_timeout = 0; m_exit = MAXC;
      for (int c = 1; c <= MAXC; c++) begin
         if (c - 1 < prog.size() && prog[c-1].en) begin
            last = c;
            if (prog[c-1].rd != 0) begin
               shadow[prog[c-1].rd] = prog[c-1].data;
               wr[prog[c-1].rd] = 1;
               m_retire++;
            end
         end
         if (c == MAXC)        begin m_exit = c; m_timeout = 1; break; end
         if (c - last == QUIET) begin m_exit = c; break; end
      end
      m_fidx = 0; m_fgot = '0;
      for (int i = 0; i < NCHK; i++) begin
         if (!failed && s_en[i] && (!wr[s_rd[i]] || shadow[s_rd[i]] != s_data[i])) begin
            failed = 1; m_fidx = i; m_fgot = wr[s_rd[i]] ? shadow[s_rd[i]] : 32'd0;
         end
      end
      m_pass = !failed && !m_timeout;
   endtask

   task automatic run(input string tag, input bit inject);
      done_edge = -1;
      sb.start = 1'b1;
      tick();
      sb.start = 1'b0;
      chk({tag, ".busy_run"}, sb.busy, 1);
      for (int c = 1; c <= 200; c++) begin
         if (c - 1 < prog.size()) begin
            sb.wb_en = prog[c-1].en; sb.wb_rd = prog[c-1].rd; sb.wb_data = prog[c-1].data;
         end else begin
            sb.wb_en = 1'b0; sb.wb_rd = '0; sb.wb_data = '0;
         end
         if (inject && c == 5) begin
            sb.start = 1'b1; sb.cfg_we = 1'b1; sb.cfg_idx = 4'd9;
            sb.cfg_rd = 5'd1; sb.cfg_data = 32'd999; sb.cfg_en = 1'b1;
         end
         tick();
         sb.start = 1'b0; sb.cfg_we = 1'b0;
         if (sb.done) begin done_edge = c; break; end
      end
      sb.wb_en = 1'b0;
      chk({tag, ".done_edge"}, done_edge, m_exit + NCHK);
   endtask

   task automatic check_result(input string tag, input bit e_pass, input bit e_to,
                               input int e_fidx, input logic [31:0] e_fgot);
      chk({tag, ".done"},       sb.done,       1);
      chk({tag, ".busy"},       sb.busy,       0);
      chk({tag, ".pass"},       sb.pass,       e_pass);
      chk({tag, ".timeout"},    sb.timeout,    e_to);
      chk({tag, ".fail_idx"},   sb.fail_idx,   e_fidx);
      chk({tag, ".fail_got"},   sb.fail_got,   e_fgot);
      chk({tag, ".cycle_cnt"},  sb.cycle_cnt,  m_exit);
      chk({tag, ".retire_cnt"}, sb.retire_cnt, m_retire);
   endtask

   initial begin
      sb.start = 0; sb.cfg_we = 0; sb.cfg_idx = '0; sb.cfg_rd = '0; sb.cfg_data = '0;
      sb.cfg_en = 0; sb.wb_en = 0; sb.wb_rd = '0; sb.wb_data = '0;

      // Reference program: bubbles, an x0 write and an overwrite of x4.
      prog_ref = '{
         '{1, 5'd1, 32'd7},  '{1, 5'd2, 32'd8},   '{0, 5'd0, 32'd0},   '{1, 5'd3, 32'd15},
         '{1, 5'd4, 32'd3},  '{1, 5'd0, 32'd5},   '{1, 5'd5, 32'd22},  '{0, 5'd9, 32'd4},
         '{0, 5'd0, 32'd0},  '{1, 5'd4, 32'd15},  '{1, 5'd6, 32'd23},  '{1, 5'd7, 32'd100},
         '{1, 5'd8, 32'd200},'{0, 5'd0, 32'd0},   '{1, 5'd10, 32'd77}
      };

      //        slot rd     data    en inj pass fidx fgot
      vecs = '{
         '{9, 5'd0, 32'd0,   0, 0, 1, 0, 32'd0},
         '{4, 5'd5, 32'd23,  1, 0, 0, 4, 32'd22},
         '{9, 5'd9, 32'd0,   1, 0, 0, 9, 32'd0},
         '{9, 5'd0, 32'd0,   1, 0, 1, 0, 32'd0},
         '{9, 5'd0, 32'd5,   1, 0, 0, 9, 32'd0},
         '{0, 5'd1, 32'd8,   1, 0, 0, 0, 32'd7},
         '{3, 5'd4, 32'd3,   1, 0, 0, 3, 32'd15},
         '{9, 5'd0, 32'd0,   0, 1, 1, 0, 32'd0}
      };

      #2;
      chk_zero("reset");
      @(negedge clk); rst = 1'b0;
      tick();

      foreach (vecs[v]) begin
         base_slots();
         s_en[vecs[v].slot] = vecs[v].en; s_rd[vecs[v].slot] = vecs[v].rd;
         s_data[vecs[v].slot] = vecs[v].data;
         program_slots();
         prog = prog_ref;
         model();
         run($sformatf("vec%0d", v), vecs[v].inject);
         check_result($sformatf("vec%0d", v), vecs[v].e_pass, 0, vecs[v].e_fidx, vecs[v].e_fgot);
      end

      // Writeback to x3 every cycle: the budget ends the run.
      base_slots(); program_slots();
      prog.delete();
      for (int i = 0; i < 60; i++) prog.push_back('{1, 5'd3, 32'(i)});
      model();
      run("budget", 0);
      chk("budget.cycle_50", sb.cycle_cnt, 50);
      chk("budget.retire_50", sb.retire_cnt, 50);
      check_result("budget", 0, 1, m_fidx, m_fgot);

      // Reset asserted between edges while scanning slots.
      base_slots(); program_slots();
      prog = prog_ref;
      sb.start = 1'b1; tick(); sb.start = 1'b0;
      for (int c = 1; c <= 38; c++) begin
         if (c - 1 < prog.size()) begin
            sb.wb_en = prog[c-1].en; sb.wb_rd = prog[c-1].rd; sb.wb_data = prog[c-1].data;
         end else sb.wb_en = 1'b0;
         tick();
      end
      chk("midchk.busy_before", sb.busy, 1);
      #2 rst = 1'b1;
      #1 chk_zero("midrst");
      @(negedge clk); rst = 1'b0;
      base_slots(); program_slots();
      model();
      run("after_rst", 0);
      check_result("after_rst", 1, 0, 0, 0);

      // Random programs and slot sets against the model.
      for (int it = 0; it < 12; it++) begin
         int len;
         for (int i = 0; i < NCHK; i++) begin
            s_en[i] = 1'($urandom_range(0, 1));
            s_rd[i] = 5'($urandom_range(0, 7));
            s_data[i] = $urandom_range(0, 3);
         end
         program_slots();
         prog.delete();
         len = (it == 11) ? 60 : int'($urandom_range(0, 40));
         for (int i = 0; i < len; i++) begin
            wb_t w;
            w.en = ($urandom_range(0, 3) != 0);
            w.rd = 5'($urandom_range(0, 7));
            w.data = $urandom_range(0, 3);
            if (it % 3 == 1 && i >= 5 && i <= 26) w.en = 1'b0;
            prog.push_back(w);
         end
         model();
         run($sformatf("rnd%0d", it), 0);
         check_result($sformatf("rnd%0d", it), m_pass, m_timeout, m_fidx, m_fgot);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

Synthesizable self-checking scoreboard for the pipelined RISC-V core. It snoops the writeback-stage register-file write port and keeps a shadow register file. Once the core goes quiet or a cycle budget expires, it compares up to NCHK programmed expectations against the shadow values. It replaces manual end-of-run register dumps with a pass/fail verdict usable in simulation and on FPGA.

## Interface
- XLEN, 32, data width of register values
- NREG, 32, architectural register count; RW = $clog2(NREG)
- NCHK, 10, number of expectation slots; CW = $clog2(NCHK)
- QUIET_CYC, 20, consecutive cycles without writeback that end a run
- MAX_CYC, 1000, cycle budget per run; CCW = $clog2(MAX_CYC+1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms a run from IDLE or DONE
- cfg_we  in  1  write an expectation slot; accepted only in IDLE/DONE
- cfg_idx  in  CW  slot index
- cfg_rd  in  RW  register checked by that slot
- cfg_data  in  XLEN  expected value
- cfg_en  in  1  slot valid bit written with the slot
- wb_en  in  1  core RegWriteW
- wb_rd  in  RW  core RdW
- wb_data  in  XLEN  core ResultW
- busy  out  1  high in RUN or CHECK
- done  out  1  verdict valid; held until the next start
- pass  out  1  all enabled slots matched and no timeout; qualified by done
- timeout  out  1  run ended by MAX_CYC, not by quiet detection
- fail_idx  out  CW  first failing slot
- fail_got  out  XLEN  shadow value at the first failing slot
- cycle_cnt  out  CCW  cycles spent in RUN; saturates at MAX_CYC
- retire_cnt  out  32  accepted writebacks in this run; wraps modulo 2^32

## Operation
- States: IDLE → RUN → CHECK → DONE; DONE → RUN on start.
- On start: clear the shadow values, written bitmap, counters, timeout, and fail fields, then enter RUN. Expectation slots are retained.
- RUN, writeback handling:
  - wb_en with wb_rd≠0: shadow[wb_rd]←wb_data, set written[wb_rd], retire_cnt+1, quiet counter←0.
  - wb_rd=0: no shadow write and no retire count, but the quiet counter still resets.
- RUN, exit conditions:
  - Quiet counter reaches QUIET_CYC → CHECK.
  - cycle_cnt reaches MAX_CYC first → CHECK with timeout=1.
  - If both occur in the same cycle, timeout=1.
- CHECK: scan slots 0..NCHK-1, one per cycle; skip disabled slots.
  - A slot fails if its register is unwritten or its shadow value ≠ cfg_data.
  - x0 is always written with value 0.
  - The first failure latches fail_idx and fail_got (0 if unwritten); later failures do not overwrite.
- DONE: done=1, pass = no failure AND timeout=0.
- cfg_we outside IDLE/DONE is ignored. start in RUN/CHECK is ignored.

## Timing
- Reset values: state IDLE; every output 0; shadow, written, and slot valid bits cleared.
- Start cycle: start sampled at edge N; RUN from N+1. A writeback presented in cycle N is not captured.
- Writebacks in RUN are captured on the same edge; one per cycle, no backpressure.
- CHECK lasts exactly NCHK cycles; done rises on the edge after the last slot is scanned.
- Quiet exit: the last writeback at edge W gives RUN→CHECK at edge W+QUIET_CYC.
- Reset mid-run: state, outputs, and slots return to reset values immediately, asynchronously.
- A writeback and the quiet-terminating edge never coincide; a writeback always restarts the quiet count.

## Structure
- Package wb_sb_pkg: state enum (IDLE, RUN, CHECK, DONE) and the default parameter constants.
- Sub-module sb_shadow_rf: NREG×XLEN shadow array with written bitmap, synchronous clear, one write port, and one combinational read port.
- Top level holds the FSM, counters, expectation slots, and verdict registers.

## Test plan
- Program slots x1=7, x2=8, x3=15, x4=15, x5=22, x6=23, x7=100, x8=200, x10=77, then run the reference program. Required: done=1, pass=1, timeout=0, and retire_cnt equals the writeback count.
- Same program with slot 4 expecting x5=23. Required: pass=0, fail_idx=4, fail_got=22.
- Slot checks x9, and x9 is flushed (never written). Required: fail with fail_got=0.
- Drive wb_en=1 every cycle to rd=3 with MAX_CYC=50. Required: CHECK entered after 50 RUN cycles, timeout=1, pass=0, cycle_cnt=50.
- Write x0=5, then check slot x0=0. Required: pass=1, retire_cnt excludes the x0 write.
- Assert rst midway through CHECK. Required: all outputs 0 next sample. A re-programmed start then completes normally.
